// File: rtl/fft_frame_loader.sv
// Ping-pong frame assembler: streams DATA_W-bit samples into N_POINTS-lane frames for the FFT core.
// Optional FRAME_BITREV_EN: write sample i to lane bitrev(i) for decimation-in-time input order.
module fft_frame_loader #(
   parameter int N_POINTS = 32,
   parameter int DATA_W   = 8
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic [DATA_W-1:0]            s_data,
   input  logic                         s_valid,
   input  logic                         s_last,
   output logic                         s_ready,
   output logic [N_POINTS*DATA_W-1:0]   m_frame,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic                         frame_err,
   output logic [15:0]                  frame_cnt
);

   localparam int CNT_W = $clog2(N_POINTS);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_POINTS - 1);

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      FULL    = 2'd2
   } buf_state_t;

   buf_state_t        state_q [2];
   buf_state_t        state_d [2];
   logic              wsel_q, wsel_d;
   logic              rsel_q, rsel_d;
   logic [CNT_W-1:0]  widx_q, widx_d;
   logic              err_d;
   logic [15:0]       cnt_d;
   logic              wr_en, rd_en;
   logic [CNT_W-1:0]  wlane;
   logic [DATA_W-1:0] mem [2][N_POINTS];

`ifdef FRAME_BITREV_EN
   function automatic logic [CNT_W-1:0] bitrev(input logic [CNT_W-1:0] idx);
      logic [CNT_W-1:0] r;
      for (int b = 0; b < CNT_W; b++) begin
         r[b] = idx[CNT_W-1-b];
      end
      return r;
   endfunction

   assign wlane = bitrev(widx_q);
`else
   assign wlane = widx_q;
`endif

   // Write side may accept while its buffer is not yet holding an undelivered frame.
   assign s_ready = (state_q[wsel_q] != FULL);
   assign m_valid = (state_q[rsel_q] == FULL);
   assign wr_en   = s_valid && s_ready;
   assign rd_en   = m_valid && m_ready;

   always_comb begin
      m_frame = '0;
      for (int l = 0; l < N_POINTS; l++) begin
         m_frame[l*DATA_W +: DATA_W] = mem[rsel_q][l];
      end
   end

   always_comb begin
      state_d = state_q;
      wsel_d  = wsel_q;
      rsel_d  = rsel_q;
      widx_d  = widx_q;
      err_d   = 1'b0;
      cnt_d   = frame_cnt;
      // Read and write always target different buffers, so both updates may land together.
      if (rd_en) begin
         state_d[rsel_q] = EMPTY;
         rsel_d          = ~rsel_q;
         cnt_d           = frame_cnt + 16'd1;
      end
      if (wr_en) begin
         if (widx_q == LAST_IDX) begin
            state_d[wsel_q] = FULL;
            wsel_d          = ~wsel_q;
            widx_d          = '0;
            err_d           = !s_last;
         end else if (s_last) begin
            state_d[wsel_q] = EMPTY;
            widx_d          = '0;
            err_d           = 1'b1;
         end else begin
            state_d[wsel_q] = FILLING;
            widx_d          = widx_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q[0] <= EMPTY;
         state_q[1] <= EMPTY;
         wsel_q     <= 1'b0;
         rsel_q     <= 1'b0;
         widx_q     <= '0;
         frame_err  <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         state_q   <= state_d;
         wsel_q    <= wsel_d;
         rsel_q    <= rsel_d;
         widx_q    <= widx_d;
         frame_err <= err_d;
         frame_cnt <= cnt_d;
      end
   end

   // Lanes are never cleared on consume; a discarded partial frame is simply overwritten.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int b = 0; b < 2; b++) begin
            for (int l = 0; l < N_POINTS; l++) begin
               mem[b][l] <= '0;
            end
         end
      end else if (wr_en) begin
         mem[wsel_q][wlane] <= s_data;
      end
   end

endmodule
